// File: rtl/xor_unpack.sv
// -----------------------------------------------------------------------------
// xor_unpack
//
// Receiving end of the byte-wide XOR cipher. Each accepted ciphertext byte is
// decrypted with a fixed key chosen by MODE. The plaintext is then packed
// little-endian into 32-bit words. A word is presented on a one-entry
// valid/ready output register, together with byte-keep and end-of-message
// marking.
//
// Parameters
//   MODE        key select: 0 -> 0xA8, 1 -> 0x02, any other value -> 0xAA
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   ct_valid    ciphertext byte present
//   ct_ready    byte accepted this cycle (combinational from ct_last/out_ready)
//   ciphertext  encrypted byte
//   ct_last     byte is the final byte of a message (qualified by ct_valid)
//   out_valid   out_word is valid
//   out_ready   consumer accepts the word
//   out_word    plaintext word, first byte in [7:0]
//   out_keep    per-lane valid bits
//   out_last    word ends a message
//   out_csum    XOR checksum of the message, shown on the last word
//
// Optional feature
//   XOR_UNPACK_CSUM_EN  when defined, the message checksum accumulator is
//                       built. Otherwise out_csum is tied to 0x00.
// -----------------------------------------------------------------------------
module xor_unpack #(
    parameter int MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ct_valid,
    output logic        ct_ready,
    input  logic [7:0]  ciphertext,
    input  logic        ct_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic [7:0]  out_csum
);

    localparam logic [7:0] KEY1 = 8'hAA;
    localparam logic [7:0] KEY2 = 8'hA8;
    localparam logic [7:0] KEY  = (MODE == 0) ? KEY2 :
                                  (MODE == 1) ? (KEY1 ^ KEY2) : KEY1;

    logic [23:0] asm_reg;          // lanes 0..2 of the word being assembled
    logic [1:0]  lane_reg;
    logic        out_valid_reg;
    logic [31:0] out_word_reg;
    logic [3:0]  out_keep_reg;
    logic        out_last_reg;

    logic [7:0]  pt;
    logic        at_last_lane;
    logic        accept;
    logic        complete;
    logic        take;
    logic [31:0] word_next;
    logic [3:0]  keep_next;

    assign pt           = ciphertext ^ KEY;
    assign at_last_lane = (lane_reg == 2'd3);

    // Partial bytes never need the output register. Only a word-completing
    // byte waits for the register to be free or draining.
    assign ct_ready = (!at_last_lane && !ct_last) || !out_valid_reg || out_ready;
    assign accept   = ct_valid && ct_ready;
    assign complete = accept && (at_last_lane || ct_last);
    assign take     = out_valid_reg && out_ready;

    // Word formation: assembled lanes below the current lane, the fresh byte
    // in the current lane, and zeros above it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE_IDX = 2'(gi);
            assign keep_next[gi] = (lane_reg >= LANE_IDX);
            if (gi < 3) begin : g_asm
                assign word_next[8*gi +: 8] = (lane_reg == LANE_IDX) ? pt :
                                              (keep_next[gi] ? asm_reg[8*gi +: 8] : 8'h00);

                always_ff @(posedge clk) begin
                    if (rst) begin
                        asm_reg[8*gi +: 8] <= 8'h00;
                    end else if (complete) begin
                        asm_reg[8*gi +: 8] <= 8'h00;
                    end else if (accept && (lane_reg == LANE_IDX)) begin
                        asm_reg[8*gi +: 8] <= pt;
                    end
                end
            end else begin : g_top
                // Lane 3 is never stored. Its byte always completes a word.
                assign word_next[8*gi +: 8] = (lane_reg == LANE_IDX) ? pt : 8'h00;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_reg <= 2'd0;
        end else if (complete) begin
            lane_reg <= 2'd0;
        end else if (accept) begin
            lane_reg <= lane_reg + 2'd1;
        end
    end

    // One-entry output register. It reloads directly on the cycle it is
    // drained, if a new word completes in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_word_reg  <= 32'h0;
            out_keep_reg  <= 4'h0;
            out_last_reg  <= 1'b0;
        end else if (complete) begin
            out_valid_reg <= 1'b1;
            out_word_reg  <= word_next;
            out_keep_reg  <= keep_next;
            out_last_reg  <= ct_last;
        end else if (take) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef XOR_UNPACK_CSUM_EN
    logic [7:0] csum_acc_reg;
    logic [7:0] csum_next;
    logic [7:0] out_csum_reg;

    assign csum_next = csum_acc_reg ^ pt;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_acc_reg <= 8'h00;
            out_csum_reg <= 8'h00;
        end else if (accept) begin
            csum_acc_reg <= (complete && ct_last) ? 8'h00 : csum_next;
            if (complete) begin
                out_csum_reg <= ct_last ? csum_next : 8'h00;
            end
        end
    end

    assign out_csum = out_csum_reg;
`else
    assign out_csum = 8'h00;
`endif

    assign out_valid = out_valid_reg;
    assign out_word  = out_word_reg;
    assign out_keep  = out_keep_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_xor_unpack.sv
// -----------------------------------------------------------------------------
// tb_xor_unpack
//
// Scoreboard bench for xor_unpack.
// - The main instance (MODE=0) gets directed and random messages. A bench
//   model predicts every word when its completing byte is accepted. A monitor
//   pops the prediction and compares it when the word transfers.
// - Two small instances (MODE=1, MODE=2) check the other key selections.
// -----------------------------------------------------------------------------
module tb_xor_unpack;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  csum;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ct_valid, ct_ready, ct_last, out_valid, out_ready, out_last;
    logic [7:0]  ciphertext, out_csum;
    logic [31:0] out_word;
    logic [3:0]  out_keep;

    logic        m1_ct_valid, m1_ct_ready, m1_ct_last, m1_out_valid, m1_out_ready, m1_out_last;
    logic [7:0]  m1_ciphertext, m1_out_csum;
    logic [31:0] m1_out_word;
    logic [3:0]  m1_out_keep;

    logic        m2_ct_valid, m2_ct_ready, m2_ct_last, m2_out_valid, m2_out_ready, m2_out_last;
    logic [7:0]  m2_ciphertext, m2_out_csum;
    logic [31:0] m2_out_word;
    logic [3:0]  m2_out_keep;

    int n_cmp = 0;
    int n_err = 0;
    int n_words = 0;
    bit rand_ready = 1'b0;

    exp_t        exp_q[$];
    int          mlane;
    logic [7:0]  masm[4];
    logic [7:0]  macc;

    always #5 clk = ~clk;

    xor_unpack #(.MODE(0)) dut (
        .clk(clk), .rst(rst), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .ciphertext(ciphertext), .ct_last(ct_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_keep(out_keep),
        .out_last(out_last), .out_csum(out_csum)
    );

    xor_unpack #(.MODE(1)) dut_m1 (
        .clk(clk), .rst(rst), .ct_valid(m1_ct_valid), .ct_ready(m1_ct_ready),
        .ciphertext(m1_ciphertext), .ct_last(m1_ct_last), .out_valid(m1_out_valid),
        .out_ready(m1_out_ready), .out_word(m1_out_word), .out_keep(m1_out_keep),
        .out_last(m1_out_last), .out_csum(m1_out_csum)
    );

    xor_unpack #(.MODE(2)) dut_m2 (
        .clk(clk), .rst(rst), .ct_valid(m2_ct_valid), .ct_ready(m2_ct_ready),
        .ciphertext(m2_ciphertext), .ct_last(m2_ct_last), .out_valid(m2_out_valid),
        .out_ready(m2_out_ready), .out_word(m2_out_word), .out_keep(m2_out_keep),
        .out_last(m2_out_last), .out_csum(m2_out_csum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mlane = 0;
        macc  = 8'h00;
        for (int i = 0; i < 4; i++) masm[i] = 8'h00;
    endtask

    // Bench model of the packer. The MODE=0 key is 0xA8.
    task automatic model_accept(input logic [7:0] ct, input logic last);
        logic [7:0] p;
        exp_t       e;
        p = ct ^ 8'hA8;
        masm[mlane] = p;
        macc = macc ^ p;
        if (mlane == 3 || last) begin
            e.word = 32'h0;
            e.keep = 4'h0;
            for (int i = 0; i <= mlane; i++) begin
                e.word[8*i +: 8] = masm[i];
                e.keep[i] = 1'b1;
            end
            e.last = last;
`ifdef XOR_UNPACK_CSUM_EN
            e.csum = last ? macc : 8'h00;
`else
            e.csum = 8'h00;
`endif
            exp_q.push_back(e);
            if (last) macc = 8'h00;
            mlane = 0;
            for (int i = 0; i < 4; i++) masm[i] = 8'h00;
        end else begin
            mlane++;
        end
    endtask

    // Offer one byte, wait (bounded) for ct_ready and return at posedge+1.
    task automatic send(input logic [7:0] b, input logic last);
        int waited;
        waited = 0;
        ciphertext = b;
        ct_last    = last;
        ct_valid   = 1'b1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (!ct_ready) begin
            waited++;
            if (waited > 200) begin
                check("send_timeout", 32'd1, 32'd0);
                ct_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        @(posedge clk);
        model_accept(b, last);
        #1;
        ct_valid = 1'b0;
        ct_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one line per delivered word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", out_word, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word", out_word, e.word);
                check("keep", 32'(out_keep), 32'(e.keep));
                check("last", 32'(out_last), 32'(e.last));
                check("csum", 32'(out_csum), 32'(e.csum));
                $display("word %0d: data=0x%08h keep=0x%h last=%0b csum=0x%02h",
                         n_words, out_word, out_keep, out_last, out_csum);
            end
            n_words++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int words_before;
        int len;
        rst = 1'b1;
        ct_valid = 1'b0; ct_last = 1'b0; ciphertext = 8'h00; out_ready = 1'b1;
        m1_ct_valid = 1'b0; m1_ct_last = 1'b0; m1_ciphertext = 8'h00; m1_out_ready = 1'b1;
        m2_ct_valid = 1'b0; m2_ct_last = 1'b0; m2_ciphertext = 8'h00; m2_out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", out_word, 32'h0);
        check("rst_out_keep", 32'(out_keep), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_csum", 32'(out_csum), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ct_ready", 32'(ct_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Full word, MODE=0, one-cycle latency.
        send(8'h02, 1'b0);
        send(8'h0B, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h0D, 1'b0);
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'd1);
        check("tp1_word", out_word, 32'hA5A2A3AA);
        check("tp1_keep", 32'(out_keep), 32'hF);
        wait_drain();

        // MODE=1 single byte with last.
        m1_ciphertext = 8'h03; m1_ct_last = 1'b1; m1_ct_valid = 1'b1;
        @(posedge clk);
        #1 m1_ct_valid = 1'b0; m1_ct_last = 1'b0;
        @(negedge clk);
        check("m1_valid", 32'(m1_out_valid), 32'd1);
        check("m1_word", m1_out_word, 32'h0000_0001);
        check("m1_keep", 32'(m1_out_keep), 32'h1);
        check("m1_last", 32'(m1_out_last), 32'd1);

        // MODE=2 two-byte message.
        @(posedge clk);
        #1 m2_ciphertext = 8'hAA; m2_ct_last = 1'b0; m2_ct_valid = 1'b1;
        @(negedge clk);
        check("m2_ct_ready", 32'(m2_ct_ready), 32'd1);
        @(posedge clk);
        #1 m2_ciphertext = 8'hAB; m2_ct_last = 1'b1;
        @(posedge clk);
        #1 m2_ct_valid = 1'b0; m2_ct_last = 1'b0;
        @(negedge clk);
        check("m2_valid", 32'(m2_out_valid), 32'd1);
        check("m2_word", m2_out_word, 32'h0000_0100);
        check("m2_keep", 32'(m2_out_keep), 32'h3);
        check("m2_last", 32'(m2_out_last), 32'd1);
`ifdef XOR_UNPACK_CSUM_EN
        check("m2_csum", 32'(m2_out_csum), 32'h01);
`else
        check("m2_csum", 32'(m2_out_csum), 32'h00);
`endif
        @(posedge clk);
        #1;

        // Last on lane 0, then a 3-byte and a 6-byte message.
        send(8'h55, 1'b1);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
        for (int i = 0; i < 6; i++) send(8'(8'h40 + i), (i == 5));
        wait_drain();

        // Backpressure: out_ready low while streaming 8 bytes.
        out_ready = 1'b0;
        words_before = n_words;
        for (int i = 0; i < 8; i++) begin
            ciphertext = 8'(8'h90 + 8'(i));
            ct_last = 1'b0;
            ct_valid = 1'b1;
            @(negedge clk);
            check("bp_ct_ready", 32'(ct_ready), (i < 7) ? 32'd1 : 32'd0);
            if (i < 7) begin
                @(posedge clk);
                model_accept(ciphertext, 1'b0);
                #1;
            end
        end
        for (int s = 0; s < 3; s++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_word", out_word, exp_q[0].word);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(ct_ready), 32'd1);
        @(posedge clk);
        model_accept(ciphertext, 1'b0);
        #1 ct_valid = 1'b0;
        wait_drain();
        check("bp_words", 32'(n_words - words_before), 32'd2);

        // Reset after two bytes of a word.
        words_before = n_words;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_rst_valid", 32'(out_valid), 32'd0);
        check("after_rst_keep", 32'(out_keep), 32'd0);
        check("after_rst_csum", 32'(out_csum), 32'd0);
        check("after_rst_words", 32'(n_words - words_before), 32'd0);
        @(posedge clk);
        #1;
        send(8'hD1, 1'b0); send(8'hD2, 1'b0); send(8'hD3, 1'b0); send(8'hD4, 1'b0);
        wait_drain();

        // Random messages with random out_ready.
        rand_ready = 1'b1;
        for (int m = 0; m < 25; m++) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) send(8'($urandom_range(0, 255)), (i == len - 1));
        end
        rand_ready = 1'b0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xor_unpack.md
# xor_unpack

Downstream stage of the byte-wide XOR cipher. It accepts a stream of 8-bit ciphertext bytes and XOR-decrypts each one with the same key selection as the encrypting stage. It packs the plaintext little-endian into 32-bit words and presents them on a valid/ready output with byte-keep and end-of-message marking. It sits between the cipher output register and the word-wide consumer.

## Interface
- `MODE`, 0: key select. 0 → key 0xA8 (KEY2); 1 → key 0x02 (KEY1^KEY2); any other value → key 0xAA (KEY1). The keys are fixed localparams, KEY1 = 0xAA and KEY2 = 0xA8.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ct_valid`  in  1  `ciphertext` holds a byte this cycle.
- `ct_ready`  out  1  block accepts a byte this cycle. A byte transfers when `ct_valid && ct_ready`.
- `ciphertext`  in  8  encrypted byte.
- `ct_last`  in  1  qualified by `ct_valid`; the byte is the final byte of a message.
- `out_valid`  out  1  `out_word` is valid.
- `out_ready`  in  1  consumer accepts. A word transfers when `out_valid && out_ready`.
- `out_word`  out  32  plaintext. First byte of a word is in [7:0], fourth byte in [31:24].
- `out_keep`  out  4  bit i set means byte lane i is valid.
- `out_last`  out  1  word ends a message.
- `out_csum`  out  8  message checksum; see Configuration.

## Operation
- Decrypt each accepted byte: `pt = ciphertext ^ KEY(MODE)`.
- Assembly register holds lanes 0..2 and a 2-bit lane counter `lane`.
- On each accepted byte:
  - If `lane < 3` and `ct_last` = 0: write `pt` into lane `lane`, then increment `lane`.
  - If `lane == 3` or `ct_last` = 1: form the word from the assembled lanes plus `pt` in lane `lane`. Set `out_keep` = lanes 0..`lane` set, and `out_last = ct_last`. Load the word into the output register in the same edge, then reset `lane` to 0.
  - Lanes above `out_keep` are driven to 0 in `out_word`.
- Output register is one entry.
  - It loads when a word completes.
  - It clears `out_valid` when the consumer takes the word and no new word completes in the same cycle.
  - If a word is taken and a new word completes in the same cycle, the register reloads and `out_valid` stays 1.
- `ct_ready = (lane != 3 && !ct_last) || !out_valid || out_ready`.
  - Partial bytes can always be absorbed.
  - A word-completing byte stalls only while the output register is full and not draining.
  - Because `ct_ready` depends on `ct_last`, it has a combinational path from `ct_last` and `out_ready`. This is intentional.
- `out_word`, `out_keep`, `out_last` and `out_csum` hold stable while `out_valid && !out_ready`.

## Timing
- Latency: one cycle from acceptance of the word-completing byte to `out_valid` = 1.
- Throughput: one byte per cycle sustained, with one word per 4 cycles for full words.
- Reset values: `out_valid` 0, `out_word` 0x00000000, `out_keep` 0x0, `out_last` 0, `out_csum` 0x00, `lane` 0, assembly register 0. `ct_ready` is 1 in the cycle after reset deasserts.
- Reset mid-operation: any partial word and any undelivered output word are discarded, with no output. The first byte after reset lands in lane 0.
- Lane counter wrap: after lane 3 the counter returns to 0 and never exceeds 3.
- `ct_last` on lane 0: emits a 1-byte word with `out_keep` = 0x1.
- `ct_valid` with `ct_ready` = 0: no state change. The source must hold the byte.

## Configuration
- Macro: `XOR_UNPACK_CSUM_EN`.
- Defined:
  - A running 8-bit XOR of all plaintext bytes of the current message, including the last byte, is loaded into `out_csum` with the `out_last` word.
  - Non-last words show `out_csum` = 0x00.
  - The accumulator clears after the last byte and on reset.
- Undefined: no accumulator logic; `out_csum` is tied to 0x00.

## Test plan
- MODE=0, `out_ready`=1, bytes 0x02, 0x0B, 0x0A, 0x0D with no `ct_last` → one cycle after the 4th byte: `out_word`=0xA5A2A3AA, `out_keep`=0xF, `out_last`=0.
- MODE=2, bytes 0xAA, 0xAB with `ct_last` on the 2nd → `out_word`=0x00000100, `out_keep`=0x3, `out_last`=1. `out_csum`=0x01 with the macro; 0x00 without it.
- MODE=1, single byte 0x03 with `ct_last` → `out_word`=0x00000001, `out_keep`=0x1, `out_last`=1.
- Backpressure: `out_ready`=0 while streaming 8 bytes →
  - the first word holds stable;
  - `ct_ready` drops only when the 8th byte is offered;
  - raising `out_ready` delivers both words in order with no loss.
- Assert `rst` for one cycle after 2 bytes of a word → no output word. The next 4 bytes form a fresh word from lane 0. `out_valid`, `out_keep` and `out_csum` read 0 during and immediately after reset.
